halt_watchdog: RTL and testbench

Synthesizable, parametrised run-termination monitor for the RV32I core bench and FPGA bring-up. It watches N commit/halt channels plus an error code. It decides when and why a run ends: halt, error after a drain window, commit-stall deadlock, or global timeout. It reports a sticky done flag with cause, channel, cycle count and commit count. It sits beside the core's RVFI outputs and replaces ad-hoc halting logic in the bench top.

---
 rtl/halt_watchdog_pkg.sv | 29 ++
 rtl/halt_watchdog_if.sv | 30 +++
 rtl/halt_watchdog_popcount_sat.sv | 27 ++
 rtl/halt_watchdog.sv | 133 +++++++++++++
 tb/tb_halt_watchdog.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/halt_watchdog_pkg.sv
// rtl/halt_watchdog_pkg.sv - shared types for the run-termination monitor
package halt_watchdog_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_HALT    = 3'd1,
    CAUSE_ERROR   = 3'd2,
    CAUSE_STALL   = 3'd3,
    CAUSE_TIMEOUT = 3'd4
  } cause_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Channel numbers are reported as the lowest set bit of the halt vector.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/halt_watchdog_if.sv
// rtl/halt_watchdog_if.sv - observation/report bundle between bench top and monitor
interface halt_watchdog_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int ERR_W  = 16
) ();
  import halt_watchdog_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] commit;
  logic [NUM_CH-1:0] halt;
  logic [ERR_W-1:0]  errcode;
  logic              done;
  cause_t            cause;
  logic [2:0]        cause_ch;
  logic [ERR_W-1:0]  err_latched;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  commit_count;

  modport master (
    output start, commit, halt, errcode,
    input  done, cause, cause_ch, err_latched, cycle_count, commit_count
  );

  modport slave (
    input  start, commit, halt, errcode,
    output done, cause, cause_ch, err_latched, cycle_count, commit_count
  );

endinterface

// File: rtl/halt_watchdog_popcount_sat.sv
// rtl/halt_watchdog_popcount_sat.sv - accumulator plus popcount of a strobe vector, clamped at all-ones
module popcount_sat #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic [CNT_W-1:0]  i_acc,
  input  logic [NUM_CH-1:0] i_bits,
  output logic [CNT_W-1:0]  o_sum
);

  localparam int WIDE_W = CNT_W + 4;

  logic [3:0]        w_pop;
  logic [WIDE_W-1:0] w_wide;

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + 4'(i_bits[i]);
    end
  end

  // Four guard bits hold any carry from adding up to eight strobes.
  assign w_wide = {4'b0000, i_acc} + WIDE_W'(w_pop);
  assign o_sum  = (w_wide[WIDE_W-1:CNT_W] != 4'b0000) ? '1 : w_wide[CNT_W-1:0];

endmodule

// File: rtl/halt_watchdog.sv
// rtl/halt_watchdog.sv - decides when and why a core run ends; sticky done with cause and counters
module halt_watchdog
  import halt_watchdog_pkg::*;
#(
  parameter int     NUM_CH         = 2,
  parameter int     CNT_W          = 32,
  parameter longint TIMEOUT_CYCLES = 100000000,
  parameter longint STALL_CYCLES   = 1000,
  parameter longint DRAIN_CYCLES   = 5,
  parameter int     ERR_W          = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  halt_watchdog_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);

  state_t           r_state;
  logic             r_done;
  cause_t           r_cause;
  logic [2:0]       r_cause_ch;
  logic [ERR_W-1:0] r_err_latched;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_commit_count;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_drain_cnt;

  logic             w_any_commit;
  logic             w_err;
  logic             w_stall_hit;
  logic             w_timeout_hit;
  logic [CNT_W-1:0] w_commit_sum;
  logic [CNT_W-1:0] w_cycle_next;
  logic [CNT_W-1:0] w_stall_next;

  popcount_sat #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_commit_acc (
    .i_acc  (r_commit_count),
    .i_bits (bus.commit),
    .o_sum  (w_commit_sum)
  );

  assign w_any_commit  = |bus.commit;
  assign w_err         = (bus.errcode != '0);
  assign w_cycle_next  = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + CNT_ONE;
  assign w_stall_next  = w_any_commit ? '0 :
                         ((r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + CNT_ONE);
  assign w_stall_hit   = (STALL_CYCLES != 0) && !w_any_commit && (r_stall_cnt == STALL_LAST);
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cycle_count == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_done         <= 1'b0;
      r_cause        <= CAUSE_NONE;
      r_cause_ch     <= 3'd0;
      r_err_latched  <= '0;
      r_cycle_count  <= '0;
      r_commit_count <= '0;
      r_stall_cnt    <= '0;
      r_drain_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state        <= ST_RUN;
            r_done         <= 1'b0;
            r_cause        <= CAUSE_NONE;
            r_cause_ch     <= 3'd0;
            r_err_latched  <= '0;
            r_cycle_count  <= '0;
            r_commit_count <= '0;
            r_stall_cnt    <= '0;
            r_drain_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_cycle_count  <= w_cycle_next;
          r_commit_count <= w_commit_sum;
          r_stall_cnt    <= w_stall_next;
          // Priority order: error, halt, stall, timeout.
          if (w_err) begin
            r_err_latched <= bus.errcode;
            r_cause       <= CAUSE_ERROR;
            r_drain_cnt   <= '0;
            if (DRAIN_CYCLES == 0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (|bus.halt) begin
            r_cause    <= CAUSE_HALT;
            r_cause_ch <= lowest_set(8'(bus.halt));
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
          end else if (w_stall_hit) begin
            r_cause <= CAUSE_STALL;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (w_timeout_hit) begin
            r_cause <= CAUSE_TIMEOUT;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.done         = r_done;
  assign bus.cause        = r_cause;
  assign bus.cause_ch     = r_cause_ch;
  assign bus.err_latched  = r_err_latched;
  assign bus.cycle_count  = r_cycle_count;
  assign bus.commit_count = r_commit_count;

endmodule

// File: tb/tb_halt_watchdog.sv
// tb/tb_halt_watchdog.sv - directed and randomized runs checked against a per-run outcome model
module tb_halt_watchdog;

  localparam int MAXC = 64;
  localparam int TO   = 50;
  localparam int ST   = 8;
  localparam int DR   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  halt_watchdog_if #(.NUM_CH(2), .CNT_W(32), .ERR_W(16)) a ();
  halt_watchdog_if #(.NUM_CH(2), .CNT_W(4),  .ERR_W(16)) b ();

  halt_watchdog #(
    .NUM_CH(2), .CNT_W(32), .TIMEOUT_CYCLES(TO), .STALL_CYCLES(ST),
    .DRAIN_CYCLES(DR), .ERR_W(16)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  halt_watchdog #(
    .NUM_CH(2), .CNT_W(4), .TIMEOUT_CYCLES(0), .STALL_CYCLES(0),
    .DRAIN_CYCLES(0), .ERR_W(16)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0]  s_commit [MAXC];
  logic [1:0]  s_halt   [MAXC];
  logic [15:0] s_err    [MAXC];
  logic        s_start  [MAXC];

  int     e_done_at, e_cause, e_ch;
  longint e_err, e_cyc, e_cmt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      s_commit[k] = 2'b00; s_halt[k] = 2'b00; s_err[k] = 16'h0; s_start[k] = 1'b0;
    end
  endtask

  // Outcome of one run from the rules: first cycle where any ending condition holds.
  function automatic void compute_model();
    int last_commit = 0;
    longint cmt = 0;
    e_done_at = -1; e_cause = 0; e_ch = 0; e_err = 0; e_cyc = 0; e_cmt = 0;
    for (int c = 1; c < MAXC; c++) begin
      int pc;
      pc = int'(s_commit[c][0]) + int'(s_commit[c][1]);
      cmt = cmt + pc;
      if (cmt > 64'hFFFF_FFFF) cmt = 64'hFFFF_FFFF;
      e_cyc = c; e_cmt = cmt;
      if (s_err[c] != 0) begin
        e_done_at = c + DR; e_cause = 2; e_err = s_err[c]; return;
      end
      if (s_halt[c] != 0) begin
        e_done_at = c; e_cause = 1; e_ch = s_halt[c][0] ? 0 : 1; return;
      end
      if (pc == 0 && (c - last_commit) >= ST) begin
        e_done_at = c; e_cause = 3; return;
      end
      if (pc > 0) last_commit = c;
      if (c == TO) begin
        e_done_at = c; e_cause = 4; return;
      end
    end
  endfunction

  task automatic start_a(input string tag);
    a.start = 1'b1; a.commit = 2'b00; a.halt = 2'b00; a.errcode = 16'h0;
    @(posedge clk); #1;
    a.start = 1'b0;
    chk({tag, "_arm_done"}, 64'(a.done), 0);
    chk({tag, "_arm_cause"}, 64'(a.cause), 0);
    chk({tag, "_arm_cyc"}, 64'(a.cycle_count), 0);
    chk({tag, "_arm_cmt"}, 64'(a.commit_count), 0);
  endtask

  task automatic drive_a(input int k);
    a.start = s_start[k]; a.commit = s_commit[k]; a.halt = s_halt[k]; a.errcode = s_err[k];
    @(posedge clk); #1;
  endtask

  task automatic run_check(input string tag);
    int first;
    compute_model();
    start_a(tag);
    first = -1;
    for (int k = 1; k < MAXC; k++) begin
      drive_a(k);
      if (a.done === 1'b1) begin
        first = k;
        break;
      end
    end
    chk({tag, "_done_at"}, 64'(first), 64'(e_done_at));
    chk({tag, "_cause"}, 64'(a.cause), 64'(e_cause));
    chk({tag, "_ch"}, 64'(a.cause_ch), 64'(e_ch));
    chk({tag, "_err"}, 64'(a.err_latched), 64'(e_err));
    chk({tag, "_cyc"}, 64'(a.cycle_count), 64'(e_cyc));
    chk({tag, "_cmt"}, 64'(a.commit_count), 64'(e_cmt));
    repeat (3) begin
      a.start = 1'b0; a.commit = 2'($urandom_range(0, 3));
      a.halt = 2'($urandom_range(0, 3)); a.errcode = 16'($urandom);
      @(posedge clk); #1;
    end
    a.commit = 2'b00; a.halt = 2'b00; a.errcode = 16'h0;
    chk({tag, "_hold_done"}, 64'(a.done), 1);
    chk({tag, "_hold_cause"}, 64'(a.cause), 64'(e_cause));
    chk({tag, "_hold_cyc"}, 64'(a.cycle_count), 64'(e_cyc));
    chk({tag, "_hold_cmt"}, 64'(a.commit_count), 64'(e_cmt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    a.start = 1'b0; a.commit = 2'b00; a.halt = 2'b00; a.errcode = 16'h0;
    b.start = 1'b0; b.commit = 2'b00; b.halt = 2'b00; b.errcode = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 64'(a.done), 0);
    chk("rst_cause", 64'(a.cause), 0);
    chk("rst_cyc", 64'(a.cycle_count), 0);
    rst_n = 1'b1;

    // Halt and error in IDLE are ignored.
    a.halt = 2'b01; a.errcode = 16'h0005;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_done", 64'(a.done), 0);
    chk("idle_cause", 64'(a.cause), 0);
    chk("idle_err", 64'(a.err_latched), 0);
    a.halt = 2'b00; a.errcode = 16'h0;

    clear_stim();
    for (int k = 1; k <= 11; k++) s_commit[k] = 2'b01;
    s_halt[11] = 2'b10;
    s_start[5] = 1'b1;
    run_check("halt");
    chk("halt_lit_ch", 64'(a.cause_ch), 1);
    chk("halt_lit_cyc", 64'(a.cycle_count), 11);
    chk("halt_lit_cmt", 64'(a.commit_count), 11);

    clear_stim();
    for (int k = 1; k < MAXC; k++) s_commit[k] = 2'b01;
    s_err[20] = 16'h0003;
    s_halt[22] = 2'b01;
    s_start[23] = 1'b1;
    run_check("error");
    chk("error_lit_done_at", 64'(e_done_at), 25);
    chk("error_lit_err", 64'(a.err_latched), 3);
    chk("error_lit_cyc", 64'(a.cycle_count), 20);

    clear_stim();
    for (int k = 1; k <= 3; k++) s_commit[k] = 2'b01;
    run_check("stall");
    chk("stall_lit_cause", 64'(a.cause), 3);
    chk("stall_lit_cyc", 64'(a.cycle_count), 11);
    chk("stall_lit_cmt", 64'(a.commit_count), 3);

    s_commit[10] = 2'b10;
    run_check("stall_late");
    chk("stall_late_lit_cyc", 64'(a.cycle_count), 18);

    clear_stim();
    for (int k = 1; k < MAXC; k++) s_commit[k] = 2'b11;
    s_halt[50] = 2'b01;
    run_check("to_halt");
    chk("to_halt_lit_cause", 64'(a.cause), 1);
    chk("to_halt_lit_cyc", 64'(a.cycle_count), 50);

    s_halt[50] = 2'b00;
    run_check("timeout");
    chk("timeout_lit_cause", 64'(a.cause), 4);
    chk("timeout_lit_cyc", 64'(a.cycle_count), 50);

    for (int r = 0; r < 10; r++) begin
      int zero_pct;
      zero_pct = $urandom_range(10, 95);
      clear_stim();
      for (int k = 1; k < MAXC; k++) begin
        s_commit[k] = ($urandom_range(0, 99) < zero_pct) ? 2'b00 : 2'($urandom_range(1, 3));
        s_halt[k]   = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        s_err[k]    = ($urandom_range(0, 69) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
        s_start[k]  = ($urandom_range(0, 15) == 0);
      end
      run_check($sformatf("rand%0d", r));
    end

    // Reset in the middle of the drain window.
    clear_stim();
    for (int k = 1; k < MAXC; k++) s_commit[k] = 2'b01;
    s_err[5] = 16'h0007;
    start_a("drain_rst");
    for (int k = 1; k <= 7; k++) drive_a(k);
    chk("drain_mid_done", 64'(a.done), 0);
    chk("drain_mid_cause", 64'(a.cause), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("drain_rst_done", 64'(a.done), 0);
    chk("drain_rst_cause", 64'(a.cause), 0);
    chk("drain_rst_err", 64'(a.err_latched), 0);
    chk("drain_rst_cyc", 64'(a.cycle_count), 0);
    chk("drain_rst_cmt", 64'(a.commit_count), 0);
    a.commit = 2'b00; a.errcode = 16'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_done", 64'(a.done), 0);

    clear_stim();
    for (int k = 1; k <= 4; k++) s_commit[k] = 2'b10;
    s_halt[4] = 2'b11;
    run_check("post_rst");

    // Narrow counters: commit count clamps, zero drain ends at once.
    b.start = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0; b.commit = 2'b11;
    repeat (10) @(posedge clk);
    #1;
    chk("sat_cmt", 64'(b.commit_count), 15);
    chk("sat_cyc", 64'(b.cycle_count), 10);
    chk("sat_done", 64'(b.done), 0);
    b.commit = 2'b00; b.errcode = 16'h0009;
    @(posedge clk); #1;
    b.errcode = 16'h0;
    chk("nodrain_done", 64'(b.done), 1);
    chk("nodrain_cause", 64'(b.cause), 2);
    chk("nodrain_err", 64'(b.err_latched), 9);
    chk("nodrain_cyc", 64'(b.cycle_count), 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
